clk_divider_prog: RTL and testbench

Parametrised, runtime-programmable multi-channel clock divider. It derives N_CH independent slow timebases from the 50 MHz system clock. Each channel produces a one-cycle tick strobe every DIV cycles and a 50 % square wave of period 2·DIV cycles. It supersedes the fixed single-channel divider as the timebase source for display scan, debounce and timekeeping logic. Divisors are loadable at runtime with glitch-free, wrap-aligned update, and all channels can be phase-aligned on command.

---
 rtl/clk_divider_prog.sv | 124 ++++++++++++
 tb/tb_clk_divider_prog.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/clk_divider_prog.sv
// -----------------------------------------------------------------------------
// clk_divider_prog
//
// Runtime-programmable multi-channel clock divider. Each channel counts system
// clock cycles and wraps every D = max(active_div, 1) enabled cycles. On each
// wrap the channel emits a one-cycle tick and toggles a 50 % square wave
// (period 2*D). New divisors land in a shadow register and only become active
// at the channel's next wrap or at a global sync, so a running period is never
// cut short by a smaller divisor.
//
// Parameters
//   N_CH        number of channels (1..16)
//   CH_W        width of i_load_ch, N_CH <= 2**CH_W
//   CNT_W       width of counters and divisor registers
//   DEFAULT_DIV divisor loaded into every channel at reset
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       synchronous reset, active-low
//   i_en        global count enable; low freezes all channels
//   i_sync      one-cycle pulse; restarts all channels in phase
//   i_load      one-cycle pulse; writes i_load_div into channel i_load_ch
//   i_load_ch   target channel for a load (values >= N_CH are ignored)
//   i_load_div  new divisor (0 behaves as 1)
//   o_tick      per-channel one-cycle strobe on wrap, registered
//   o_out_clk   per-channel square wave, registered
//   o_pending   per-channel flag: loaded divisor not yet active
//
// Handshake: there is no valid/ready flow control. i_load and i_sync are
// single-cycle command strobes that are always accepted on the edge where
// they are high; the block never stalls them.
// -----------------------------------------------------------------------------
module clk_divider_prog #(
  parameter int          N_CH        = 4,
  parameter int          CH_W        = 2,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 25000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CH_W-1:0]  i_load_ch,
  input  logic [CNT_W-1:0] i_load_div,
  output logic [N_CH-1:0]  o_tick,
  output logic [N_CH-1:0]  o_out_clk,
  output logic [N_CH-1:0]  o_pending
);

  localparam logic [CNT_W-1:0] C_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active_div;
    logic [CNT_W-1:0] r_shadow_div;
    logic             r_pending;
    logic             r_tick;
    logic             r_out_clk;

    logic [CNT_W-1:0] w_div_eff;
    logic             w_load_hit;
    logic             w_wrap;

    // A zero divisor is stored as written but counts as 1.
    assign w_div_eff  = (r_active_div == '0) ? C_ONE : r_active_div;
    // Channel indices >= N_CH match no generate instance, so such loads
    // fall through with no effect.
    assign w_load_hit = i_load && (i_load_ch == CH_W'(gi));
    // The wrap decision always uses the divisor active before this edge.
    assign w_wrap     = i_en && (r_cnt == (w_div_eff - C_ONE));

    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        r_cnt        <= '0;
        r_active_div <= C_DEFAULT_DIV;
        r_shadow_div <= C_DEFAULT_DIV;
        r_pending    <= 1'b0;
        r_tick       <= 1'b0;
        r_out_clk    <= 1'b0;
      end else if (i_sync) begin
        // Sync restarts the phase and is a divisor-update point, like a wrap.
        r_cnt     <= '0;
        r_tick    <= 1'b0;
        r_out_clk <= 1'b0;
        r_pending <= 1'b0;
        if (w_load_hit) begin
          r_active_div <= i_load_div;
          r_shadow_div <= i_load_div;
        end else if (r_pending) begin
          r_active_div <= r_shadow_div;
        end
      end else if (w_wrap) begin
        r_cnt     <= '0;
        r_tick    <= 1'b1;
        r_out_clk <= ~r_out_clk;
        r_pending <= 1'b0;
        // A load on the wrap edge goes straight to the active divisor.
        if (w_load_hit) begin
          r_active_div <= i_load_div;
          r_shadow_div <= i_load_div;
        end else if (r_pending) begin
          r_active_div <= r_shadow_div;
        end
      end else begin
        // Counting without wrap, or frozen by en=0; loads only reach the shadow.
        if (i_en) begin
          r_cnt <= r_cnt + C_ONE;
        end
        r_tick <= 1'b0;
        if (w_load_hit) begin
          r_shadow_div <= i_load_div;
          r_pending    <= 1'b1;
        end
      end
    end

    assign o_tick[gi]    = r_tick;
    assign o_out_clk[gi] = r_out_clk;
    assign o_pending[gi] = r_pending;
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_divider_prog
//
// Drives a 3-channel divider (DEFAULT_DIV = 5) through a table of stimulus
// segments. Each segment holds its inputs for n cycles; the expected
// {tick, out_clk, pending} after the last cycle is pushed to a queue when that
// cycle is driven and popped and compared once the edge has passed. A
// hand-written sequence afterwards exercises D = 1 entered via sync+load.
// -----------------------------------------------------------------------------
module tb_clk_divider_prog;

  localparam int N_CH  = 3;
  localparam int CH_W  = 2;
  localparam int CNT_W = 32;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic             rst_n    = 1'b0;
  logic             en       = 1'b0;
  logic             sync     = 1'b0;
  logic             load     = 1'b0;
  logic [CH_W-1:0]  load_ch  = '0;
  logic [CNT_W-1:0] load_div = '0;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  out_clk;
  logic [N_CH-1:0]  pending;

  clk_divider_prog #(
    .N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W), .DEFAULT_DIV(5)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_sync(sync), .i_load(load),
    .i_load_ch(load_ch), .i_load_div(load_div),
    .o_tick(tick), .o_out_clk(out_clk), .o_pending(pending)
  );

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic             rst_n;
    logic             en;
    logic             sync;
    logic             load;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] div;
    int               n;
    logic [N_CH-1:0]  t;
    logic [N_CH-1:0]  o;
    logic [N_CH-1:0]  p;
    string            name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic s, input logic l,
                     input logic [CH_W-1:0] c, input logic [CNT_W-1:0] d,
                     input int n, input logic [N_CH-1:0] t,
                     input logic [N_CH-1:0] o, input logic [N_CH-1:0] p,
                     input string nm);
    vec_t v;
    v.rst_n = r; v.en = e; v.sync = s; v.load = l; v.ch = c; v.div = d;
    v.n = n; v.t = t; v.o = o; v.p = p; v.name = nm;
    vecs.push_back(v);
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [3*N_CH-1:0] exp_q[$];
  string             name_q[$];
  int                n_checks = 0;
  int                n_pass   = 0;

  task automatic check_out();
    logic [3*N_CH-1:0] exp_v;
    logic [3*N_CH-1:0] got_v;
    string             nm;
    exp_v = exp_q.pop_front();
    nm    = name_q.pop_front();
    got_v = {tick, out_clk, pending};
    n_checks++;
    if (got_v !== exp_v)
      $display("FAIL %s: got tick=%b out_clk=%b pending=%b, expected tick=%b out_clk=%b pending=%b",
               nm, got_v[8:6], got_v[5:3], got_v[2:0], exp_v[8:6], exp_v[5:3], exp_v[2:0]);
    else
      n_pass++;
  endtask

  task automatic drive(input logic r, input logic e, input logic s, input logic l,
                       input logic [CH_W-1:0] c, input logic [CNT_W-1:0] d);
    rst_n = r; en = e; sync = s; load = l; load_ch = c; load_div = d;
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    // rst_n en sync load ch div n tick out pend name
    add(0,0,0,0,0, 0, 2, 3'b000, 3'b000, 3'b000, "reset");
    add(1,1,0,0,0, 0, 4, 3'b000, 3'b000, 3'b000, "count_e4");
    add(1,1,0,0,0, 0, 1, 3'b111, 3'b111, 3'b000, "wrap_e5");
    add(1,1,0,0,0, 0, 1, 3'b000, 3'b111, 3'b000, "after_wrap_e6");
    add(1,1,0,0,0, 0, 4, 3'b111, 3'b000, 3'b000, "wrap_e10");
    add(1,1,0,0,0, 0, 5, 3'b111, 3'b111, 3'b000, "wrap_e15");
    add(1,1,0,0,0, 0, 1, 3'b000, 3'b111, 3'b000, "p2_e1");
    add(1,1,0,1,1, 3, 1, 3'b000, 3'b111, 3'b010, "load_ch1_e2");
    add(1,1,0,0,0, 0, 2, 3'b000, 3'b111, 3'b010, "pending_hold");
    add(1,1,0,0,0, 0, 1, 3'b111, 3'b000, 3'b000, "wrap_swap_e5");
    add(1,1,0,0,0, 0, 3, 3'b010, 3'b010, 3'b000, "ch1_div3_e8");
    add(1,1,0,0,0, 0, 2, 3'b101, 3'b111, 3'b000, "others_div5_e10");
    add(1,1,0,0,0, 0, 1, 3'b010, 3'b101, 3'b000, "ch1_div3_e11");
    add(1,1,0,1,0, 0, 1, 3'b000, 3'b101, 3'b001, "load_zero_ch0");
    add(1,1,1,0,0, 0, 1, 3'b000, 3'b000, 3'b000, "sync_after_zero");
    add(1,1,0,0,0, 0, 1, 3'b001, 3'b001, 3'b000, "d1_edge1");
    add(1,1,0,0,0, 0, 1, 3'b001, 3'b000, 3'b000, "d1_edge2");
    add(1,1,0,0,0, 0, 1, 3'b011, 3'b011, 3'b000, "d1_edge3");
    add(1,0,0,1,0, 3, 1, 3'b000, 3'b011, 3'b001, "load3_en0");
    add(1,0,0,1,1, 4, 1, 3'b000, 3'b011, 3'b011, "load4_en0");
    add(1,0,0,1,2, 7, 1, 3'b000, 3'b011, 3'b111, "load7_en0");
    add(1,0,1,0,0, 0, 1, 3'b000, 3'b000, 3'b000, "sync_en0");
    add(1,1,0,0,0, 0, 2, 3'b000, 3'b000, 3'b000, "phase_e2");
    add(1,1,0,0,0, 0, 1, 3'b001, 3'b001, 3'b000, "div3_first");
    add(1,1,0,0,0, 0, 1, 3'b010, 3'b011, 3'b000, "div4_first");
    add(1,1,0,0,0, 0, 3, 3'b100, 3'b110, 3'b000, "div7_first");
    add(1,0,0,0,0, 0, 4, 3'b000, 3'b110, 3'b000, "freeze_a");
    add(1,0,0,1,3, 9, 1, 3'b000, 3'b110, 3'b000, "load_bad_ch");
    add(1,0,0,0,0, 0, 5, 3'b000, 3'b110, 3'b000, "freeze_b");
    add(1,1,0,0,0, 0, 1, 3'b010, 3'b100, 3'b000, "resume_1");
    add(1,1,0,0,0, 0, 1, 3'b001, 3'b101, 3'b000, "resume_2");
    add(1,1,0,0,0, 0, 2, 3'b000, 3'b101, 3'b000, "pre_wrap");
    add(1,1,0,1,0, 2, 1, 3'b011, 3'b110, 3'b000, "load_at_wrap");
    add(1,1,0,0,0, 0, 1, 3'b000, 3'b110, 3'b000, "post_load_wrap");
    add(1,1,0,0,0, 0, 1, 3'b101, 3'b011, 3'b000, "new_div2_wrap");
    add(1,1,0,1,2, 6, 1, 3'b000, 3'b011, 3'b100, "load_before_rst");
    add(0,1,0,0,0, 0, 1, 3'b000, 3'b000, 3'b000, "reset_mid");
    add(1,1,0,0,0, 0, 4, 3'b000, 3'b000, 3'b000, "post_rst_e4");
    add(1,1,0,0,0, 0, 1, 3'b111, 3'b111, 3'b000, "post_rst_e5");

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        drive(vecs[i].rst_n, vecs[i].en, vecs[i].sync, vecs[i].load,
              vecs[i].ch, vecs[i].div);
        if (c == vecs[i].n - 1) begin
          exp_q.push_back({vecs[i].t, vecs[i].o, vecs[i].p});
          name_q.push_back(vecs[i].name);
        end
        @(posedge clk);
        #1;
        if (c == vecs[i].n - 1) check_out();
      end
    end

    // D = 1 entered by a load in the same cycle as sync: the divisor becomes
    // active at once. Channels 0 and 2 stay at 5.
    drive(1, 1, 1, 1, 2'd1, 32'd1);
    exp_q.push_back({3'b000, 3'b000, 3'b000});
    name_q.push_back("sync_load_d1");
    @(posedge clk);
    #1;
    check_out();
    for (int k = 1; k <= 6; k++) begin
      logic [N_CH-1:0] t_e;
      logic [N_CH-1:0] o_e;
      drive(1, 1, 0, 0, 2'd0, 32'd0);
      t_e    = (k % 5 == 0) ? 3'b111 : 3'b010;
      o_e[0] = (k >= 5);
      o_e[2] = (k >= 5);
      o_e[1] = (k % 2 == 1);
      exp_q.push_back({t_e, o_e, 3'b000});
      name_q.push_back($sformatf("d1_run_%0d", k));
      @(posedge clk);
      #1;
      check_out();
    end

    drive(1, 0, 0, 0, 2'd0, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
